// File: rtl/qerv_timer_pkg.sv
// Shared address map, reset constants and byte-lane merge helper for qerv_timer.
package qerv_timer_pkg;

  localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADR_PRESCALE    = 3'd4;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] wb_merge(input logic [31:0] old,
                                           input logic [31:0] dat,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = dat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/qerv_timer_prescaler.sv
// Prescale register and divider counter; o_tick strobes when the counter hits the prescale value.
module qerv_timer_prescaler #(
  parameter RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [15:0] i_dat,
  input  logic [1:0]  i_sel,
  output logic [15:0] o_prescale,
  output logic        o_tick
);

  localparam bit RST_ALL = (RESET_STRATEGY != "NONE");

  logic [15:0] cnt;

  assign o_tick = (cnt == o_prescale);

  always_ff @(posedge i_clk) begin
    if (i_rst && RST_ALL) begin
      o_prescale <= '0;
      cnt        <= '0;
    end else if (i_we) begin
      if (i_sel[0]) o_prescale[7:0]  <= i_dat[7:0];
      if (i_sel[1]) o_prescale[15:8] <= i_dat[15:8];
      // Restart the division so the new ratio applies from a clean phase
      cnt <= '0;
    end else if (o_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/qerv_timer.sv
// Machine timer (mtime/mtimecmp) with a Wishbone classic slave port and level interrupt.
// Optional prescaler at 0x10 enabled by defining QERV_TIMER_PRESCALER_EN.
module qerv_timer
  import qerv_timer_pkg::*;
#(
  parameter RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);

  localparam bit RST_ALL = (RESET_STRATEGY != "NONE");

  logic        acc_p0;
  logic        wr_p0;
  logic [2:0]  adr;
  logic        tick;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] rdata;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;

  // A request arriving during reset is dropped rather than acked later
  assign acc_p0 = i_wb_cyc & i_wb_stb & ~o_wb_ack & ~i_rst;
  assign wr_p0  = acc_p0 & i_wb_we;

`ifdef QERV_TIMER_PRESCALER_EN
  logic [15:0] prescale;

  assign adr = i_wb_adr;

  qerv_timer_prescaler #(
    .RESET_STRATEGY(RESET_STRATEGY)
  ) u_prescaler (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we       (wr_p0 && (adr == ADR_PRESCALE)),
    .i_dat      (i_wb_dat[15:0]),
    .i_sel      (i_wb_sel[1:0]),
    .o_prescale (prescale),
    .o_tick     (tick)
  );
`else
  logic unused_adr;

  // Upper word-address bit is don't-care: 0x10-0x1C alias the four timer registers
  assign unused_adr = i_wb_adr[2];
  assign adr        = {1'b0, i_wb_adr[1:0]};
  assign tick       = 1'b1;
`endif

  assign wr_mtime_lo = wr_p0 && (adr == ADR_MTIME_LO);
  assign wr_mtime_hi = wr_p0 && (adr == ADR_MTIME_HI);
  assign wr_cmp_lo   = wr_p0 && (adr == ADR_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_p0 && (adr == ADR_MTIMECMP_HI);

  always_comb begin
    rdata = '0;
    case (adr)
      ADR_MTIME_LO:    rdata = mtime[31:0];
      ADR_MTIME_HI:    rdata = mtime[63:32];
      ADR_MTIMECMP_LO: rdata = mtimecmp[31:0];
      ADR_MTIMECMP_HI: rdata = mtimecmp[63:32];
`ifdef QERV_TIMER_PRESCALER_EN
      ADR_PRESCALE:    rdata = {16'h0000, prescale};
`endif
      default:         rdata = '0;
    endcase
  end

  // p0 -> p1: acknowledge is the registered accept strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) o_wb_ack <= 1'b0;
    else       o_wb_ack <= acc_p0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && RST_ALL) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      o_irq    <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      // Any mtime write freezes the whole counter so software sees exactly what it wrote
      if (wr_mtime_lo || wr_mtime_hi) begin
        if (wr_mtime_lo) mtime[31:0]  <= wb_merge(mtime[31:0],  i_wb_dat, i_wb_sel);
        if (wr_mtime_hi) mtime[63:32] <= wb_merge(mtime[63:32], i_wb_dat, i_wb_sel);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (wr_cmp_lo) mtimecmp[31:0]  <= wb_merge(mtimecmp[31:0],  i_wb_dat, i_wb_sel);
      if (wr_cmp_hi) mtimecmp[63:32] <= wb_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
      if (acc_p0)    o_wb_rdt        <= rdata;
      o_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_qerv_timer.sv
// Scoreboard bench for qerv_timer: bus tasks queue expected read ranges, a monitor checks them on ack.
module tb_qerv_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] rdt;
  logic        ack, irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          chk;
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  qerv_timer dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_sel (sel),
    .i_wb_we  (we),
    .i_wb_cyc (cyc),
    .i_wb_stb (stb),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack),
    .o_irq    (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no pending access");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) begin
          checks++;
          if ($isunknown(rdt) || rdt < mon_e.lo || rdt > mon_e.hi) begin
            errors++;
            $display("FAIL %s: got %h expected %h..%h", mon_e.name, rdt, mon_e.lo, mon_e.hi);
          end
        end
      end
    end
  end

  task automatic bus(input logic [2:0] a, input bit w, input logic [31:0] d,
                     input logic [3:0] s, input string name, input bit chk,
                     input logic [31:0] lo, input logic [31:0] hi);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.name = name; e.chk = chk; e.lo = lo; e.hi = hi;
    sb.push_back(e);
    adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      got = (ack === 1'b1);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 4 cycles", name);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(a, 1'b1, d, s, "write", 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] lo, input logic [31:0] hi);
    bus(a, 1'b0, 32'h0, 4'h0, name, 1'b1, lo, hi);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int         first;
    logic [5:0] pat;
    exp_t       e;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    idle(3);
    check("rst_ack", ack, 0);
    check("rst_irq", irq, 0);
    check("rst_rdt", rdt, 0);
    rst = 1'b0;

    // Free-running count after reset
    idle(9);
    check("idle_irq", irq, 0);
    rd(3'd0, "mtime_lo_idle", 32'd9, 32'd11);
    rd(3'd1, "mtime_hi_idle", 32'd0, 32'd0);

    // Carry from low into high word
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    wr(3'd1, 32'h0, 4'hF);
    idle(3);
    rd(3'd1, "carry_hi", 32'd1, 32'd1);
    rd(3'd0, "carry_lo", 32'd5, 32'd5);

    // Interrupt rise exactly one cycle after mtime reaches mtimecmp
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd0, 32'h0, 4'hF);
    wr(3'd2, 32'd40, 4'hF);
    wr(3'd3, 32'h0, 4'hF);
    first = -1;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      if (irq === 1'b1 && first < 0) first = 4 + j;
    end
    check("irq_rise_edge", first, 41);
    rd(3'd2, "cmp_lo_rd", 32'd40, 32'd40);
    wr(3'd3, 32'h1, 4'hF);
    check("irq_hold", irq, 1);
    @(negedge clk);
    check("irq_fall", irq, 0);

    // Held request: one access every second cycle
    e.name = "held"; e.chk = 1'b0; e.lo = 0; e.hi = 0;
    for (int k = 0; k < 3; k++) sb.push_back(e);
    @(negedge clk);
    adr = 3'd0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    pat[0] = ack;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      pat[k] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_pattern", {26'd0, pat}, 32'b101010);

    // Reset during a pending write drops it
    @(negedge clk);
    adr = 3'd0; we = 1'b1; dat = 32'h1234_5678; sel = 4'hF; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("rst_midtx_ack", ack, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rst2_ack", ack, 0);
    check("rst2_rdt", rdt, 0);
    rst = 1'b0;
    rd(3'd0, "post_rst_mtime_lo", 32'd1, 32'd1);
    rd(3'd1, "post_rst_mtime_hi", 32'd0, 32'd0);
    rd(3'd2, "post_rst_cmp_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(3'd3, "post_rst_cmp_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("post_rst_irq", irq, 0);

    // Byte-lane write
    wr(3'd2, 32'h0000_AB00, 4'b0010);
    rd(3'd2, "cmp_lo_bytes", 32'hFFFF_ABFF, 32'hFFFF_ABFF);
    rd(3'd3, "cmp_hi_bytes", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

`ifdef QERV_TIMER_PRESCALER_EN
    rd(3'd6, "hole_0x18_rd", 32'h0, 32'h0);
    wr(3'd7, 32'h10, 4'hF);
    rd(3'd3, "hole_0x1c_wr", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Divide by 4, counter phase restarted by the prescale write
    wr(3'd4, 32'd3, 4'hF);
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd0, 32'h0, 4'hF);
    idle(38);
    rd(3'd0, "presc3_mtime", 32'd9, 32'd9);
    rd(3'd4, "prescale_rd", 32'd3, 32'd3);
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'h0, 4'hF);
    idle(8);
    rd(3'd0, "presc0_mtime", 32'd9, 32'd9);
    rd(3'd5, "hole_0x14_rd", 32'h0, 32'h0);
`else
    rd(3'd6, "alias_0x18_rd", 32'hFFFF_ABFF, 32'hFFFF_ABFF);
    wr(3'd7, 32'h10, 4'hF);
    rd(3'd3, "alias_0x1c_wr", 32'h10, 32'h10);
`endif

    idle(2);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qerv_timer.md
Name: qerv_timer

Overview:
- Machine timer peripheral for the qerv core: free-running 64-bit mtime and a 64-bit mtimecmp compare register.
- Produces the level timer interrupt that drives the CSR unit's i_mtip input.
- Registers are accessed over a 32-bit Wishbone classic slave port on the core's peripheral bus.

Parameters:
- RESET_STRATEGY, "MINI", "MINI" resets all state. "NONE" resets only o_wb_ack.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_wb_adr  in  3  word address, byte address bits [4:2]
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte lane enables
- i_wb_we  in  1  write enable
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- o_wb_rdt  out  32  read data, valid while o_wb_ack=1
- o_wb_ack  out  1  single-cycle acknowledge
- o_irq  out  1  timer interrupt level, connects to i_mtip

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values (MINI):
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - o_wb_ack = 0, o_irq = 0, o_wb_rdt = 0
- Reset mid-transaction: the pending access is dropped and no ack is issued.
- Address map (byte offsets):
  - 0x0 mtime[31:0]
  - 0x4 mtime[63:32]
  - 0x8 mtimecmp[31:0]
  - 0xC mtimecmp[63:32]
  - 0x10-0x1C: see Optional Feature. Without it, i_wb_adr[2] is ignored, these addresses alias 0x0-0xC, and i_wb_adr[1:0] selects the register.
- Handshake:
  - An access is accepted when i_wb_cyc & i_wb_stb & !o_wb_ack.
  - o_wb_ack=1 on the next cycle, for exactly one cycle.
  - Back-to-back requests therefore complete every second cycle.
  - Writes commit on the accept edge.
  - Read data is registered on the accept edge and presented together with o_wb_ack.
- Byte lanes: writes honour i_wb_sel per byte. Reads ignore i_wb_sel.
- Counting:
  - mtime increments by 1 every cycle as a full 64-bit add, carry from bit 31 into bit 32.
  - Wraps from all-ones to 0.
  - Tick gating is changed by the Optional Feature.
- Write vs. increment: a write to either mtime half suppresses the increment of the whole 64-bit mtime in that cycle. The unwritten bytes hold their value.
- Interrupt:
  - o_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
  - Latency is one cycle after a register change.
  - Level signal: it stays high until mtimecmp is raised above mtime or mtime wraps.
- Read coherency: reading the lo half does not latch the hi half. Software uses the hi-lo-hi sequence.

Optional Feature:
- Macro: QERV_TIMER_PRESCALER_EN.
- With macro:
  - Adds a 16-bit prescale register at 0x10. Reads return it zero-extended; writes use bytes 0-1 only. Reset value 0.
  - Adds a 16-bit prescale counter, reset 0.
  - mtime ticks in a cycle only if counter == prescale; the counter then returns to 0, otherwise it increments.
  - prescale = 0 gives a tick every cycle.
  - A write to the prescale register clears the counter in the same cycle.
  - Addresses 0x14-0x1C read 0 and ignore writes, but are still acked.
- Without macro: mtime ticks every cycle, no prescale logic, and aliasing applies as above.

Decomposition:
- Shared package qerv_timer_pkg holds:
  - address offset localparams: ADR_MTIME_LO, ADR_MTIME_HI, ADR_MTIMECMP_LO, ADR_MTIMECMP_HI, ADR_PRESCALE
  - MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
- Sub-module qerv_timer_prescaler, instantiated only under QERV_TIMER_PRESCALER_EN. It holds the prescale register and counter and outputs a tick strobe.

Test Plan:
- Reset, then idle 10 cycles -> o_irq=0. Read 0x0 returns a value in 9..11. Read 0x4 returns 0.
- Write 0x0=0xFFFF_FFFE and 0x4=0, then wait 3 cycles and read 0x4 -> 1 (carry propagated). Read 0x0 returns a small value.
- Write mtimecmp_hi=0 and mtimecmp_lo=mtime_lo+20 -> o_irq rises exactly one cycle after mtime reaches the compare value. Rewrite 0xC=1 -> o_irq falls one cycle later.
- Write 0x8 with i_wb_sel=4'b0010 and data 0x0000_AB00 -> only byte 1 changes. Read 0x8 = 0xFFFF_ABFF.
- Hold cyc/stb high for 6 cycles -> ack pattern 0,1,0,1,0,1. Assert i_rst during a pending access -> no ack. All registers return to reset values.
- With QERV_TIMER_PRESCALER_EN: write 0x10=3 -> mtime advances once every 4 cycles. Write 0x10=0 -> mtime advances every cycle.
